// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder and sequential instruction-memory loader.
// Packs R/I/J field bundles into 32-bit words, queues them, writes memory.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   in_valid/ready  field bundle handshake (in_ready = FIFO not full)
//   in_opcode..     instruction fields (opcode, rs, rt, rd, shamt,
//   in_target       funct, imm, target)
//   mem_we/addr     memory write request and word address
//   mem_wdata       encoded word being written
//   mem_ack         memory accepted the current write
//   err             one-cycle pulse: bundle rejected
//   overflow        sticky: write address wrapped past all-ones
//
// Optional build macro: ENCODE_CHECK_EN adds field-legality checks.
module mips_instr_encoder #(
    parameter int          DEPTH      = 4,
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_opcode,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    output logic                  err,
    output logic                  overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]    state;
    logic [31:0]   fifoMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;

    logic [31:0] encWord;
    logic        encLegal;
    logic        accept;
    logic        doPush;
    logic        doPop;

    // Combinational encode of the presented bundle.
    always_comb begin
        encWord  = '0;
        encLegal = 1'b0;
        case (in_opcode)
            6'h00: begin
                encWord  = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
                encLegal = 1'b1;
`ifdef ENCODE_CHECK_EN
                if (!(in_funct inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h22,
                                       6'h24, 6'h25, 6'h27, 6'h2A}))
                    encLegal = 1'b0;
                // Shifts take their operand from rt; rs must be zero.
                if ((in_funct == 6'h00 || in_funct == 6'h02) && in_rs != 5'd0)
                    encLegal = 1'b0;
                if (!(in_funct == 6'h00 || in_funct == 6'h02) && in_shamt != 5'd0)
                    encLegal = 1'b0;
`endif
            end
            6'h02, 6'h03: begin
                encWord  = {in_opcode, in_target};
                encLegal = 1'b1;
            end
            6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B: begin
                encWord  = {in_opcode, in_rs, in_rt, in_imm};
                encLegal = 1'b1;
`ifdef ENCODE_CHECK_EN
                if (in_opcode == 6'h0F && in_rs != 5'd0)
                    encLegal = 1'b0;
`endif
            end
            default: begin
                encWord  = '0;
                encLegal = 1'b0;
            end
        endcase
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign doPush    = accept && encLegal;
    assign mem_we    = (state == WRITE);
    assign doPop     = mem_we && mem_ack;
    assign mem_wdata = mem_we ? fifoMem[rdPtr] : 32'd0;
    assign countNext = count + CW'(doPush) - CW'(doPop);

    always_ff @(posedge clk) begin
        if (doPush)
            fifoMem[wrPtr] <= encWord;
    end

    // State is WRITE exactly when the FIFO will hold a word next cycle,
    // so a word pushed into an empty FIFO is presented one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            mem_addr <= ADDR_WIDTH'(BASE_ADDR);
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= (countNext != '0) ? WRITE : IDLE;
            count <= countNext;
            err   <= accept && !encLegal;
            if (doPush)
                wrPtr <= wrPtr + PW'(1);
            if (doPop) begin
                rdPtr    <= rdPtr + PW'(1);
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                if (&mem_addr)
                    overflow <= 1'b1;
            end
        end
    end
endmodule
